mem_arbiter: RTL and testbench

Arbiter and sequencer that shares one single-ported unified memory between the CPU's instruction-fetch path and its data load/store path. It accepts one request at a time, issues a single-cycle read or write strobe to the memory, waits a fixed memory latency, and returns data with a one-cycle ready pulse to the owning requester. The ready pulses act as the CPU's fetch and data stall releases. Arbitration gives data priority, with an optional starvation guard for fetch.

---
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter sequencing one single-ported memory; data has priority.
// Define MEM_ARB_STARVE_GUARD_EN to force a fetch grant after STARVE_LIMIT contested data grants.
module mem_arbiter #(
    parameter int unsigned MEM_LAT      = 2,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_rdy,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    output logic [15:0] dm_rdata,
    output logic        dm_rdy,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_re,
    output logic        mem_we,
    input  logic [15:0] mem_rdata,
    output logic        busy
);

    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_lat_chk
        $error("MEM_LAT out of range");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_lim_chk
        $error("STARVE_LIMIT out of range");
    end

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

    state_e      state_q, state_d;
    logic        en_q;
    logic [3:0]  cnt_q, cnt_d;
    logic        grant, grant_data, done;
    logic        own_data_q, we_q;
    logic [15:0] addr_q, wdata_q, if_rdata_q, dm_rdata_q;
    logic        if_rdy_q, dm_rdy_q;

    // en_q holds off arbitration for the first cycle after reset release
    assign grant = (state_q == S_IDLE) && en_q && (if_req || dm_req);
    assign done  = (state_q == S_WAIT) && (cnt_q == 4'd1);

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0] streak_q, streak_d;
    logic       force_if;

    assign force_if   = if_req && dm_req && (streak_q == LIMIT);
    assign grant_data = dm_req && !force_if;

    always_comb begin
        streak_d = streak_q;
        if (grant) begin
            if (grant_data && if_req) streak_d = streak_q + 4'd1;
            else                      streak_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) streak_q <= '0;
        else        streak_q <= streak_d;
    end
`else
    assign grant_data = dm_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (grant) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_re = (state_q == S_ISSUE) && !we_q;
        mem_we = (state_q == S_ISSUE) && we_q;
        busy   = (state_q == S_ISSUE) || (state_q == S_WAIT);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_ISSUE)     cnt_d = LAT;
        else if (state_q == S_WAIT) cnt_d = cnt_q - 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q       <= 1'b0;
            cnt_q      <= '0;
            own_data_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_rdy_q   <= 1'b0;
            dm_rdy_q   <= 1'b0;
        end else begin
            en_q     <= 1'b1;
            cnt_q    <= cnt_d;
            if_rdy_q <= done && !own_data_q;
            dm_rdy_q <= done && own_data_q;
            if (grant) begin
                own_data_q <= grant_data;
                we_q       <= grant_data && dm_we;
                addr_q     <= grant_data ? dm_addr : if_addr;
                wdata_q    <= grant_data ? dm_wdata : '0;
            end
            if (done) begin
                if (own_data_q) dm_rdata_q <= mem_rdata;
                else            if_rdata_q <= mem_rdata;
            end
        end
    end

    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_rdy    = if_rdy_q;
    assign dm_rdy    = dm_rdy_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: default instance plus a MEM_LAT=1 instance.
module tb_mem_arbiter;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    typedef struct {
        bit          is_data;
        bit          chk;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic        clk, rst_n;
    logic        if_req, dm_req, dm_we;
    logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_rdy, dm_rdy, mem_re, mem_we, busy;

    logic        if_req1;
    logic [15:0] if_addr1, mem_rdata1;
    logic [15:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1;
    logic        if_rdy1, dm_rdy1, mem_re1, mem_we1, busy1;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   due0 = -100, due1 = -100;
    logic [15:0] val0, val1, got0;
    logic [15:0] mem [logic [15:0]];
    exp_t q0[$], q1[$];
    exp_t e0, e1;

    mem_arbiter u_dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_rdy(if_rdy),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_rdy(dm_rdy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.MEM_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_rdy(if_rdy1),
        .dm_req(1'b0), .dm_we(1'b0), .dm_addr(16'h0000), .dm_wdata(16'h0000),
        .dm_rdata(dm_rdata1), .dm_rdy(dm_rdy1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_re(mem_re1), .mem_we(mem_we1),
        .mem_rdata(mem_rdata1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] memv(input logic [15:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 16'h3C3C;
    endfunction

    // Memory models: read data is valid only in cycle strobe+MEM_LAT, garbage otherwise
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_re) begin due0 = cyc + 2; val0 = memv(mem_addr); end
            if (mem_we) mem[mem_addr] = mem_wdata;
            if (mem_re1) begin due1 = cyc + 1; val1 = mem_addr1 ^ 16'h3C3C; end
        end
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        mem_rdata  = (cyc == due0) ? val0 : (16'hDEAD ^ 16'(cyc));
        mem_rdata1 = (cyc == due1) ? val1 : (16'hBEEF ^ 16'(cyc));
    end

    always @(negedge clk) begin
        if (if_rdy || dm_rdy) begin
            checks++;
            if (if_rdy && dm_rdy) begin
                errors++;
                $display("FAIL dut0_both_rdy: got if_rdy=1 dm_rdy=1, expected at most one");
            end else if (q0.size() == 0) begin
                errors++;
                $display("FAIL dut0_unexpected_rdy: got if_rdy=%0b dm_rdy=%0b at cyc %0d, expected none", if_rdy, dm_rdy, cyc);
            end else begin
                e0 = q0.pop_front();
                if (dm_rdy !== e0.is_data || cyc != e0.cyc) begin
                    errors++;
                    $display("FAIL dut0_owner_cycle: got data=%0b cyc=%0d, expected data=%0b cyc=%0d", dm_rdy, cyc, e0.is_data, e0.cyc);
                end
                if (e0.chk) begin
                    checks++;
                    got0 = dm_rdy ? dm_rdata : if_rdata;
                    if (got0 !== e0.data) begin
                        errors++;
                        $display("FAIL dut0_rdata: got %h, expected %h at cyc %0d", got0, e0.data, cyc);
                    end
                end
            end
        end
        if (if_rdy1 || dm_rdy1) begin
            checks++;
            if (dm_rdy1 || q1.size() == 0) begin
                errors++;
                $display("FAIL lat1_unexpected_rdy: got if_rdy=%0b dm_rdy=%0b at cyc %0d, expected none", if_rdy1, dm_rdy1, cyc);
            end else begin
                e1 = q1.pop_front();
                if (cyc != e1.cyc || if_rdata1 !== e1.data) begin
                    errors++;
                    $display("FAIL lat1_completion: got cyc=%0d rdata=%h, expected cyc=%0d rdata=%h", cyc, if_rdata1, e1.cyc, e1.data);
                end
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b1; if_req = 0; dm_req = 0; dm_we = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; if_req1 = 0; if_addr1 = '0;
        mem[16'h0010] = 16'hA5A5;
        #2 rst_n = 1'b0;
        repeat (3) step();
        checks++;
        if ({if_rdata, dm_rdata, mem_addr, mem_wdata, if_rdy, dm_rdy, mem_re, mem_we, busy} !== '0) begin
            errors++;
            $display("FAIL reset_dut0: got re=%0b we=%0b busy=%0b addr=%h, expected all 0", mem_re, mem_we, busy, mem_addr);
        end
        checks++;
        if ({if_rdata1, dm_rdata1, mem_addr1, mem_wdata1, if_rdy1, dm_rdy1, mem_re1, mem_we1, busy1} !== '0) begin
            errors++;
            $display("FAIL reset_lat1: got re=%0b busy=%0b, expected all 0", mem_re1, busy1);
        end
        rst_n = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_fetch;
        int t;
        step(); t = cyc;
        if_req = 1; if_addr = 16'h0010;
        q0.push_back('{1'b0, 1'b1, 16'hA5A5, t + 4});
        step();
        checks++;
        if ({mem_re, mem_we, busy} !== 3'b101 || mem_addr !== 16'h0010) begin
            errors++;
            $display("FAIL fetch_strobe: got re=%0b we=%0b busy=%0b addr=%h, expected 1 0 1 0010", mem_re, mem_we, busy, mem_addr);
        end
        step();
        checks++;
        if (mem_re !== 1'b0) begin
            errors++;
            $display("FAIL fetch_strobe_width: got mem_re=%0b, expected 0", mem_re);
        end
        step(); step();
        if_req = 0;
        repeat (2) step();
        checks++;
        if (if_rdata !== 16'hA5A5 || busy !== 1'b0) begin
            errors++;
            $display("FAIL fetch_hold: got if_rdata=%h busy=%0b, expected a5a5 0", if_rdata, busy);
        end
    endtask

    task automatic test_store;
        int t;
        step(); t = cyc;
        dm_req = 1; dm_we = 1; dm_addr = 16'h0200; dm_wdata = 16'h1234;
        q0.push_back('{1'b1, 1'b0, 16'h0000, t + 4});
        step();
        checks++;
        if ({mem_re, mem_we} !== 2'b01 || mem_addr !== 16'h0200 || mem_wdata !== 16'h1234) begin
            errors++;
            $display("FAIL store_strobe: got re=%0b we=%0b addr=%h wdata=%h, expected 0 1 0200 1234", mem_re, mem_we, mem_addr, mem_wdata);
        end
        dm_addr = 16'h0BAD; dm_wdata = 16'hFFFF;
        step();
        checks++;
        if ({mem_re, mem_we} !== 2'b00 || mem_addr !== 16'h0200 || mem_wdata !== 16'h1234) begin
            errors++;
            $display("FAIL store_after: got re=%0b we=%0b addr=%h wdata=%h, expected 0 0 0200 1234", mem_re, mem_we, mem_addr, mem_wdata);
        end
        step(); step();
        dm_req = 0; dm_we = 0;
        step(); t = cyc;
        dm_req = 1; dm_addr = 16'h0200;
        q0.push_back('{1'b1, 1'b1, 16'h1234, t + 4});
        repeat (4) step();
        dm_req = 0;
        step();
    endtask

    task automatic test_contention;
        int t;
        bit f;
        step(); t = cyc;
        if_addr = 16'h0040; dm_addr = 16'h0300; dm_we = 0;
        if_req = 1; dm_req = 1;
        for (int k = 0; k < 12; k++) begin
            f = GUARD && (k % 4 == 3);
            q0.push_back('{!f, 1'b1, f ? memv(16'h0040) : memv(16'h0300), t + 4 * (k + 1)});
        end
        repeat (48) step();
        if_req = 0; dm_req = 0;
        repeat (2) step();
    endtask

    task automatic test_drop;
        int t;
        int nre;
        step(); t = cyc;
        dm_req = 1; dm_we = 0; dm_addr = 16'h0300;
        q0.push_back('{1'b1, 1'b1, memv(16'h0300), t + 4});
        nre = 0;
        step();
        dm_req = 0;
        for (int i = 0; i < 8; i++) begin
            if (mem_re) nre++;
            step();
        end
        checks++;
        if (nre != 1) begin
            errors++;
            $display("FAIL drop_strobes: got %0d read strobes, expected 1", nre);
        end
    endtask

    task automatic test_reset_mid;
        int r;
        step();
        if_req = 1; if_addr = 16'h0050;
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({if_rdata, dm_rdata, mem_addr, mem_wdata, if_rdy, dm_rdy, mem_re, mem_we, busy} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got busy=%0b addr=%h if_rdata=%h, expected all 0", busy, mem_addr, if_rdata);
        end
        step();
        rst_n = 1'b1; r = cyc;
        step();
        checks++;
        if (mem_re !== 1'b0) begin
            errors++;
            $display("FAIL reset_early_strobe: got mem_re=%0b one cycle after release, expected 0", mem_re);
        end
        step();
        checks++;
        if (mem_re !== 1'b1 || mem_addr !== 16'h0050) begin
            errors++;
            $display("FAIL reset_reissue: got mem_re=%0b addr=%h, expected 1 0050", mem_re, mem_addr);
        end
        q0.push_back('{1'b0, 1'b1, memv(16'h0050), r + 5});
        repeat (3) step();
        if_req = 0;
        repeat (2) step();
    endtask

    task automatic test_lat1_back_to_back;
        int t;
        logic [15:0] a;
        step(); t = cyc;
        if_req1 = 1;
        for (int k = 0; k < 5; k++) begin
            a = 16'h0100 + 16'(k);
            if_addr1 = a;
            q1.push_back('{1'b0, 1'b1, a ^ 16'h3C3C, t + 3 * (k + 1)});
            step();
            if_addr1 = 16'hFFFF;
            step(); step();
        end
        if_req1 = 0;
        repeat (3) step();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_contention();
        test_drop();
        test_reset_mid();
        test_lat1_back_to_back();
        repeat (4) step();
        checks++;
        if (q0.size() != 0) begin
            errors++;
            $display("FAIL dut0_missing_rdy: got %0d pending, expected 0", q0.size());
        end
        checks++;
        if (q1.size() != 0) begin
            errors++;
            $display("FAIL lat1_missing_rdy: got %0d pending, expected 0", q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
